// File: rtl/adder_pkg.sv
// Shared constants and helpers for the ALU-style adder datapath.
package adder_pkg;

  localparam int ADDER_DEFAULT_N = 32;

  // Signed overflow of a two's-complement add: the MSB saw a carry in
  // that did not propagate out, or a carry out that had no carry in.
  function automatic logic signed_overflow(input logic c_into_msb,
                                           input logic c_out_of_msb);
    return c_into_msb ^ c_out_of_msb;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; one link of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/adder_n_reg.sv
// N-bit ripple-carry adder with carry-in, registered sum/carry/overflow and a
// one-cycle valid pipeline.
module adder_n_reg
  import adder_pkg::*;
#(
  parameter int N = ADDER_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic         o_valid
);

  // Handshake: i_valid qualifies a/b/c_in for one cycle and is always accepted
  // (no ready). o_valid is high exactly one cycle after each accepted add;
  // while it is low, sum/c_out/overflow keep the last captured result.

  logic [N:0]   c;
  logic [N-1:0] s;
  logic         ovf;

  assign c[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_ripple
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (c[i]),
      .sum   (s[i]),
      .c_out (c[i+1])
    );
  end

  // For N=1 the carry into the MSB is c[0], i.e. c_in itself.
  assign ovf = signed_overflow(c[N-1], c[N]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        sum      <= s;
        c_out    <= c[N];
        overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_adder_n_reg.sv
// Directed and random checks of adder_n_reg at N=32 and N=8 side by side.
module tb_adder_n_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        c_in = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic        c_out, overflow, o_valid;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        c_out8, overflow8, o_valid8;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {o_valid, overflow, c_out, sum}; hold_* tracks the last capture.
  logic [34:0] exp_q[$];
  logic [10:0] exp_q8[$];
  logic [34:0] hold32 = '0;
  logic [10:0] hold8 = '0;

  always #5 clk = ~clk;

  adder_n_reg #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .a(a), .b(b), .c_in(c_in),
    .sum(sum), .c_out(c_out), .overflow(overflow), .o_valid(o_valid)
  );

  adder_n_reg #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .a(a8), .b(b8), .c_in(c_in),
    .sum(sum8), .c_out(c_out8), .overflow(overflow8), .o_valid(o_valid8)
  );

  task automatic cmp(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one vector for a single cycle, then check both DUTs against the model.
  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic [7:0] va8, input logic [7:0] vb8,
                       input logic vc, input logic vv);
    logic [32:0] f;
    logic [8:0]  f8;
    @(negedge clk);
    a = va; b = vb; a8 = va8; b8 = vb8; c_in = vc; i_valid = vv;
    f  = {1'b0, va} + {1'b0, vb} + 33'(vc);
    f8 = {1'b0, va8} + {1'b0, vb8} + 9'(vc);
    if (vv) begin
      hold32 = {1'b1, (va[31] == vb[31]) && (f[31] != va[31]), f[32], f[31:0]};
      hold8  = {1'b1, (va8[7] == vb8[7]) && (f8[7] != va8[7]), f8[8], f8[7:0]};
    end else begin
      hold32 = {1'b0, hold32[33:0]};
      hold8  = {1'b0, hold8[9:0]};
    end
    exp_q.push_back(hold32);
    exp_q8.push_back(hold8);
    @(posedge clk);
    #1;
    cmp("model32", {o_valid, overflow, c_out, sum}, exp_q.pop_front());
    cmp("model8", {24'b0, o_valid8, overflow8, c_out8, sum8}, {24'b0, exp_q8.pop_front()});
  endtask

  // Hand-computed expectation for the 32-bit instance.
  task automatic expect32(input string tag, input logic v, input logic ov,
                          input logic co, input logic [31:0] s);
    cmp(tag, {o_valid, overflow, c_out, sum}, {v, ov, co, s});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect32("reset32", 1'b0, 1'b0, 1'b0, 32'h0);
    cmp("reset8", {24'b0, o_valid8, overflow8, c_out8, sum8}, 35'h0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(32'h0, 32'h0, 8'h00, 8'h00, 1'b0, 1'b1);
    expect32("zero", 1'b1, 1'b0, 1'b0, 32'h0000_0000);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 8'hFF, 8'h01, 1'b0, 1'b1);
    expect32("wrap", 1'b1, 1'b0, 1'b1, 32'h0000_0000);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    expect32("ones_cin", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    drive(32'h7FFF_FFFF, 32'h0000_0001, 8'h7F, 8'h01, 1'b0, 1'b1);
    expect32("pos_ovf", 1'b1, 1'b1, 1'b0, 32'h8000_0000);
    drive(32'h8000_0000, 32'h8000_0000, 8'h80, 8'h80, 1'b0, 1'b1);
    expect32("neg_ovf", 1'b1, 1'b1, 1'b1, 32'h0000_0000);
    drive(32'h0, 32'h0, 8'h00, 8'h00, 1'b1, 1'b1);
    expect32("cin_only", 1'b1, 1'b0, 1'b0, 32'h0000_0001);
    drive(32'h7FFF_FFFF, 32'h0, 8'h7F, 8'h00, 1'b1, 1'b1);
    expect32("cin_ovf", 1'b1, 1'b1, 1'b0, 32'h8000_0000);

    // Back-to-back accepts, then a hold cycle.
    drive(32'd1, 32'd2, 8'd1, 8'd2, 1'b0, 1'b1);
    expect32("b2b_0", 1'b1, 1'b0, 1'b0, 32'd3);
    drive(32'd3, 32'd4, 8'd3, 8'd4, 1'b0, 1'b1);
    expect32("b2b_1", 1'b1, 1'b0, 1'b0, 32'd7);
    drive(32'd5, 32'd6, 8'd5, 8'd6, 1'b0, 1'b1);
    expect32("b2b_2", 1'b1, 1'b0, 1'b0, 32'd11);
    drive(32'd9, 32'd9, 8'd9, 8'd9, 1'b1, 1'b0);
    expect32("hold", 1'b0, 1'b0, 1'b0, 32'd11);
    drive(32'hAAAA_0000, 32'h5555_0000, 8'h12, 8'h34, 1'b0, 1'b1);
    expect32("pre_rst", 1'b1, 1'b0, 1'b0, 32'hFFFF_0000);

    // Asynchronous reset between edges, then release with i_valid low.
    #3;
    rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    expect32("async_rst32", 1'b0, 1'b0, 1'b0, 32'h0);
    cmp("async_rst8", {24'b0, o_valid8, overflow8, c_out8, sum8}, 35'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hold32 = '0;
    hold8  = '0;
    drive(32'h1234_5678, 32'h1111_1111, 8'h44, 8'h55, 1'b0, 1'b0);
    expect32("post_rst_idle", 1'b0, 1'b0, 1'b0, 32'h0);
    drive(32'h1234_5678, 32'h1111_1111, 8'h44, 8'h55, 1'b0, 1'b1);
    expect32("post_rst_add", 1'b1, 1'b0, 1'b0, 32'h2345_6789);

    for (int i = 0; i < 1000; i++) begin
      drive($urandom, $urandom, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
